// File: rtl/vx_gbar_unit_pkg.sv
// Shared definitions for the global barrier unit: default sizing,
// arrival classification and the ceil-log2 helper used for port widths.
package vx_gbar_unit_pkg;

  localparam int DEF_NUM_BARRIERS = 8;
  localparam int DEF_NUM_CORES    = 4;

  // How a single accepted arrival affects the addressed barrier
  typedef enum logic [1:0] {
    ARR_DROP    = 2'd0,
    ARR_DUP     = 2'd1,
    ARR_JOIN    = 2'd2,
    ARR_RELEASE = 2'd3
  } arrival_e;

  // Ceil-log2 with a floor of one bit so single-entry configs still get a port
  function automatic int log2up(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/vx_gbar_unit_pipe_reg.sv
// Optional register chain on the release broadcast; DEPTH of zero is a wire.
module vx_gbar_unit_pipe_reg #(
  parameter int DATAW = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DATAW-1:0] data_i,
  output logic [DATAW-1:0] data_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk, reset};
    assign data_o    = data_i;
  end else begin : g_regs
    logic [DATAW-1:0] stage_q [DEPTH];

    // Shift the broadcast through DEPTH stages; reset squashes anything in flight
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign data_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vx_gbar_unit.sv
// Cluster-level global barrier controller: counts arrivals per barrier ID
// and broadcasts the ID back once the last participant has arrived.
module vx_gbar_unit
  import vx_gbar_unit_pkg::*;
#(
  parameter  int NUM_BARRIERS = DEF_NUM_BARRIERS,
  parameter  int NUM_CORES    = DEF_NUM_CORES,
  parameter  int OUT_REG      = 0,
  localparam int NB_WIDTH     = log2up(NUM_BARRIERS),
  localparam int NC_WIDTH     = log2up(NUM_CORES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid_i,
  input  logic [NB_WIDTH-1:0] req_id_i,
  input  logic [NC_WIDTH-1:0] req_size_m1_i,
  input  logic [NC_WIDTH-1:0] req_core_id_i,
  output logic                req_ready_o,
  output logic                rsp_valid_o,
  output logic [NB_WIDTH-1:0] rsp_id_o,
  output logic                busy_o
);

  localparam int CW = NC_WIDTH + 1;

  logic [NUM_CORES-1:0] mask_q  [NUM_BARRIERS];
  logic [CW-1:0]        count_q [NUM_BARRIERS];
  logic [CW-1:0]        count_d [NUM_BARRIERS];
  logic [NC_WIDTH-1:0]  size_q  [NUM_BARRIERS];

  logic                 accept, id_ok, core_ok;
  arrival_e             arrival;
  logic [NUM_CORES-1:0] sel_mask;
  logic [CW-1:0]        sel_count;
  logic [NC_WIDTH-1:0]  sel_size, eff_size;
  logic                 busy_d, busy_q;
  logic                 rsp_valid_q;
  logic [NB_WIDTH-1:0]  rsp_id_q;

  // The unit never stalls, so ready simply tracks being out of reset
  assign req_ready_o = ~reset;
  assign accept      = req_valid_i & req_ready_o;
  assign id_ok       = (32'(req_id_i) < 32'(NUM_BARRIERS));
  assign core_ok     = (32'(req_core_id_i) < 32'(NUM_CORES));

  // Classify the incoming arrival against the addressed barrier's state
  always_comb begin
    arrival   = ARR_DROP;
    sel_mask  = '0;
    sel_count = '0;
    sel_size  = '0;
    eff_size  = '0;
    if (accept && id_ok && core_ok) begin
      sel_mask  = mask_q[req_id_i];
      sel_count = count_q[req_id_i];
      sel_size  = size_q[req_id_i];
      eff_size  = (sel_count == '0) ? req_size_m1_i : sel_size;
      if (sel_mask[req_core_id_i])            arrival = ARR_DUP;
      else if (sel_count == {1'b0, eff_size}) arrival = ARR_RELEASE;
      else                                    arrival = ARR_JOIN;
    end
  end

  // Next counts for every ID, and whether any barrier remains pending afterwards
  always_comb begin
    busy_d = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      count_d[b] = count_q[b];
      if (32'(b) == 32'(req_id_i)) begin
        if (arrival == ARR_RELEASE)   count_d[b] = '0;
        else if (arrival == ARR_JOIN) count_d[b] = sel_count + CW'(1);
      end
      busy_d = busy_d | (count_d[b] != '0);
    end
  end

  // Per-ID barrier state plus the registered release and busy flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        mask_q[b]  <= '0;
        count_q[b] <= '0;
        size_q[b]  <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) count_q[b] <= count_d[b];
      if (arrival == ARR_RELEASE) begin
        mask_q[req_id_i] <= '0;
      end else if (arrival == ARR_JOIN) begin
        mask_q[req_id_i][req_core_id_i] <= 1'b1;
        if (sel_count == '0) size_q[req_id_i] <= req_size_m1_i;
      end
      rsp_valid_q <= (arrival == ARR_RELEASE);
      if (arrival == ARR_RELEASE) rsp_id_q <= req_id_i;
      busy_q <= busy_d;
    end
  end

  // Flag protocol misuse by the upstream arbiters; the hardware tolerates it
  always_ff @(posedge clk) begin
    if (!reset && req_valid_i) begin
      assert (id_ok && core_ok)
        else $warning("gbar: out-of-range id %0d or core %0d dropped", req_id_i, req_core_id_i);
      assert (arrival != ARR_DUP)
        else $warning("gbar: duplicate arrival id %0d core %0d ignored", req_id_i, req_core_id_i);
      assert (!((arrival == ARR_JOIN || arrival == ARR_RELEASE) && sel_count != '0
                && req_size_m1_i != sel_size))
        else $warning("gbar: size change on id %0d, keeping %0d", req_id_i, sel_size);
    end
  end

  vx_gbar_unit_pipe_reg #(
    .DATAW (1 + NB_WIDTH),
    .DEPTH (OUT_REG)
  ) u_out_reg (
    .clk    (clk),
    .reset  (reset),
    .data_i ({rsp_valid_q, rsp_id_q}),
    .data_o ({rsp_valid_o, rsp_id_o})
  );

  assign busy_o = busy_q;

endmodule

// File: tb/tb_vx_gbar_unit.sv
// Directed bench for vx_gbar_unit: a default instance and an OUT_REG=1
// instance share the same request stream.
module tb_vx_gbar_unit;

  logic       clk;
  logic       reset;
  logic       reqValid;
  logic [2:0] reqId;
  logic [1:0] reqSizeM1;
  logic [1:0] reqCoreId;

  logic       reqReady,  rspValid,  busy;
  logic [2:0] rspId;
  logic       reqReady2, rspValid2, busy2;
  logic [2:0] rspId2;

  int checks = 0;
  int errors = 0;

  vx_gbar_unit #(.NUM_BARRIERS(8), .NUM_CORES(4), .OUT_REG(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (reqValid),
    .req_id_i      (reqId),
    .req_size_m1_i (reqSizeM1),
    .req_core_id_i (reqCoreId),
    .req_ready_o   (reqReady),
    .rsp_valid_o   (rspValid),
    .rsp_id_o      (rspId),
    .busy_o        (busy)
  );

  vx_gbar_unit #(.NUM_BARRIERS(8), .NUM_CORES(4), .OUT_REG(1)) dutReg (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (reqValid),
    .req_id_i      (reqId),
    .req_size_m1_i (reqSizeM1),
    .req_core_id_i (reqCoreId),
    .req_ready_o   (reqReady2),
    .rsp_valid_o   (rspValid2),
    .rsp_id_o      (rspId2),
    .busy_o        (busy2)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one request (or idle) for a full cycle; returns at the next falling edge
  task automatic applyStimulus(input logic v, input int id, input int sizeM1, input int core);
    reqValid  = v;
    reqId     = 3'(id);
    reqSizeM1 = 2'(sizeM1);
    reqCoreId = 2'(core);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset     = 1'b1;
    reqValid  = 1'b0;
    reqId     = '0;
    reqSizeM1 = '0;
    reqCoreId = '0;
    repeat (2) @(negedge clk);

    // Reset values
    checkOutput("rst_ready", 32'(reqReady), 0);
    checkOutput("rst_rsp_valid", 32'(rspValid), 0);
    checkOutput("rst_rsp_id", 32'(rspId), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_rsp_valid_reg", 32'(rspValid2), 0);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_rst", 32'(reqReady), 1);
    @(negedge clk);

    // Four cores join barrier 2 (size_m1=3)
    applyStimulus(1, 2, 3, 0);
    checkOutput("b2_c0_rsp", 32'(rspValid), 0);
    checkOutput("b2_c0_busy", 32'(busy), 1);
    applyStimulus(1, 2, 3, 1);
    checkOutput("b2_c1_rsp", 32'(rspValid), 0);
    applyStimulus(1, 2, 3, 2);
    checkOutput("b2_c2_rsp", 32'(rspValid), 0);
    checkOutput("b2_c2_busy", 32'(busy), 1);
    applyStimulus(1, 2, 3, 3);
    checkOutput("b2_release_valid", 32'(rspValid), 1);
    checkOutput("b2_release_id", 32'(rspId), 2);
    checkOutput("b2_release_busy", 32'(busy), 0);
    checkOutput("b2_reg_not_yet", 32'(rspValid2), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("b2_pulse_ends", 32'(rspValid), 0);
    checkOutput("b2_reg_valid", 32'(rspValid2), 1);
    checkOutput("b2_reg_id", 32'(rspId2), 2);
    applyStimulus(0, 0, 0, 0);
    checkOutput("b2_reg_pulse_ends", 32'(rspValid2), 0);

    // Interleaved barriers 0 and 5, each with two participants
    applyStimulus(1, 0, 1, 0);
    checkOutput("il_0c0_rsp", 32'(rspValid), 0);
    applyStimulus(1, 5, 1, 1);
    checkOutput("il_5c1_rsp", 32'(rspValid), 0);
    applyStimulus(1, 0, 1, 2);
    checkOutput("il_rel0_valid", 32'(rspValid), 1);
    checkOutput("il_rel0_id", 32'(rspId), 0);
    checkOutput("il_rel0_busy", 32'(busy), 1);
    applyStimulus(1, 5, 1, 3);
    checkOutput("il_rel5_valid", 32'(rspValid), 1);
    checkOutput("il_rel5_id", 32'(rspId), 5);
    checkOutput("il_rel5_busy", 32'(busy), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("il_idle_rsp", 32'(rspValid), 0);

    // Duplicate arrival on barrier 1 must not count
    applyStimulus(1, 1, 1, 0);
    checkOutput("dup_first_rsp", 32'(rspValid), 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("dup_second_rsp", 32'(rspValid), 0);
    checkOutput("dup_second_busy", 32'(busy), 1);
    applyStimulus(1, 1, 1, 3);
    checkOutput("dup_release_valid", 32'(rspValid), 1);
    checkOutput("dup_release_id", 32'(rspId), 1);
    checkOutput("dup_release_busy", 32'(busy), 0);

    // Single-participant barrier 7 releases on every arrival
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 7, 0, 2);
      checkOutput($sformatf("solo_%0d_valid", i), 32'(rspValid), 1);
      checkOutput($sformatf("solo_%0d_id", i), 32'(rspId), 7);
      checkOutput($sformatf("solo_%0d_busy", i), 32'(busy), 0);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("solo_idle_rsp", 32'(rspValid), 0);

    // Reset in the middle of barrier 3 discards the earlier arrivals
    applyStimulus(1, 3, 3, 0);
    applyStimulus(1, 3, 3, 1);
    checkOutput("mid_pre_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_ready_low", 32'(reqReady), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    applyStimulus(1, 3, 3, 2);
    checkOutput("mid_c2_rsp", 32'(rspValid), 0);
    applyStimulus(1, 3, 3, 3);
    checkOutput("mid_c3_rsp", 32'(rspValid), 0);
    checkOutput("mid_c3_busy", 32'(busy), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("mid_idle_rsp", 32'(rspValid), 0);
    checkOutput("mid_idle_busy", 32'(busy), 1);

    // Barrier 3 completes with cores 0 and 1; reset squashes the delayed copy
    applyStimulus(1, 3, 3, 0);
    checkOutput("sq_c0_rsp", 32'(rspValid), 0);
    applyStimulus(1, 3, 3, 1);
    checkOutput("sq_release_valid", 32'(rspValid), 1);
    checkOutput("sq_release_id", 32'(rspId), 3);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0);
    checkOutput("sq_reg_squashed", 32'(rspValid2), 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("sq_reg_still_quiet", 32'(rspValid2), 0);
    checkOutput("sq_busy_clear", 32'(busy2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
